muxn_pipe: RTL and testbench
============================

// Module: muxn_pipe
// PURPOSE
//   Parametrised N:1 multiplexer with a registered output stage and valid/ready
//   handshake. Successor to the combinational 2:1 mux. Adds WIDTH-bit data, N
//   input channels, one output register and a selectable arbitration mode.
//   MODE 0 uses an external select. MODE 1 uses round-robin over valid channels.
//   Sits between N producers and one consumer.
// PARAMETERS
//   WIDTH  8   data width per channel, >=1
//   N      4   number of input channels, >=2
//   MODE   0   0 = external select (sel), 1 = round-robin arbitration (sel ignored)
//   SELW   $clog2(N)   derived select/channel-index width; do not override
// PORTS
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous reset, active low
//   in_data    in   N*WIDTH    channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid   in   N          per-channel valid
//   in_ready   out  N          per-channel ready (combinational)
//   sel        in   SELW       channel select, used in MODE 0 only
//   out_data   out  WIDTH      registered output data
//   out_valid  out  1          registered output valid
//   out_ch     out  SELW       index of the channel that supplied out_data
//   out_ready  in   1          consumer ready
// BEHAVIOUR
//   Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
//     Takes effect immediately. Any held word is discarded. in_ready=0 while in reset.
//   Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
//   accept = !out_valid || out_ready. A full register with out_ready=1 is refilled
//     in the same cycle. Full throughput: 1 word/cycle.
//   Channel k transfers when in_valid[k] && in_ready[k]. At most one in_ready bit is
//     high per cycle.
//   MODE 0: g = sel.
//     in_ready[g] = accept. All other in_ready bits are 0.
//     If sel >= N, there is no grant and all in_ready bits are 0.
//   MODE 1: g = first k with in_valid[k]=1, scanning ptr, ptr+1, ... with mod-N wrap.
//     in_ready[g] = accept && in_valid[g]. No valid channel means no grant.
//     On a transfer: ptr <= (g+1) mod N.
//     Without a transfer, ptr holds.
//   Transfer at edge t: out_data <= in_data[g], out_ch <= g, out_valid <= 1 at t+1.
//     Latency is 1 cycle.
//   No transfer && out_ready: out_valid <= 0 (EMPTY).
//   Stall (out_valid && !out_ready): out_data and out_ch hold stable. All in_ready=0.
//   Simultaneous pop and push: the new word replaces the old one. out_valid stays 1.
//     No bubble and no loss.
//   A change of sel while stalled has no effect until accept=1. No word is duplicated
//     or dropped.
//   Inputs are sampled only on a transfer. out_data does not depend combinationally
//     on the inputs.
// TESTING
//   T1 reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0,
//      out_ch=0 without waiting for a clock edge. ptr=0 after release.
//   T2 MODE0 N=4 W=8: sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1
//      -> in_ready=4'b0100. Next cycle out_data=A5, out_ch=2, out_valid=1.
//   T3 MODE0 stall: out_ready=0 for 3 cycles with ch2 valid -> in_ready=0,
//      out_data holds A5. Then out_ready=1 with new ch2=8'h3C
//      -> out_data=3C next cycle, out_valid stays 1.
//   T4 MODE1 fairness: all 4 channels always valid, out_ready=1
//      -> out_ch sequence 0,1,2,3,0,1 with one word per cycle.
//   T5 MODE1 skip and wrap: ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2.
//      in_valid=0 -> no grant, and out_valid=0 after the pop.
//   T6 MODE0 out-of-range: N=3, sel=3 -> in_ready=3'b000 and out_valid stays 0.

Source files
------------

// File: rtl/muxn_pipe.sv
// muxn_pipe: N:1 multiplexer feeding a single registered output stage with a
// valid/ready handshake. The channel comes from sel (MODE 0) or from a
// round-robin scan over the valid channels (MODE 1).
//
// Handshake: a word moves on any port when valid && ready are both high in the
// same rising clk edge. Valid must not depend on ready. in_ready is
// combinational from the output register state and out_ready. out_valid and
// out_data are registered only.
module muxn_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);

  // Output register occupancy. out_valid is the state, visible to checkers.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] scan_idx;
  logic            grant_ok;
  logic            accept;
  logic            xfer;

  // Pick the granted channel: sel directly, or the first valid channel at or
  // after the round-robin pointer. Out-of-range sel grants nothing.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    scan_idx = '0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        grant    = sel;
        grant_ok = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        scan_idx = SELW'((int'(ptr_q) + i) % N);
        if (!grant_ok && in_valid[scan_idx]) begin
          grant    = scan_idx;
          grant_ok = 1'b1;
        end
      end
    end
  end

  // Handshake and next-state: refill when empty or when the held word is
  // being popped. The pointer moves past the winner only on a real transfer.
  always_comb begin
    accept   = (state_q == ST_EMPTY) || out_ready;
    in_ready = '0;
    if (rst_n && grant_ok && accept) begin
      in_ready[grant] = 1'b1;
    end
    xfer    = rst_n && grant_ok && accept && in_valid[grant];
    state_d = state_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = ST_FULL;
      if (MODE != 0) begin
        ptr_d = SELW'((int'(grant) + 1) % N);
      end
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Occupancy and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output data/channel register. Loads only on a transfer, so it holds
  // through stalls and never follows the inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (xfer) begin
      out_data <= in_data[grant*WIDTH +: WIDTH];
      out_ch   <= grant;
    end
  end

  assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: three muxn_pipe instances (MODE0 N=4, MODE1 N=4, MODE0 N=3)
// driven from per-instance stimulus arrays and checked every cycle against a
// depth-1 queue model of the output register plus directed scenario checks.
module tb_muxn_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus arrays (index = instance) ----------------
  logic [3:0] st_v   [3];
  logic [1:0] st_sel [3];
  logic       st_rdy [3];
  logic [7:0] st_dat [3][4];

  // ---------------- DUT signals ----------------
  logic [31:0] in_data0, in_data1;
  logic [23:0] in_data2;
  logic [3:0]  in_valid0, in_valid1, in_ready0, in_ready1;
  logic [2:0]  in_valid2, in_ready2;
  logic [1:0]  sel0, sel1, sel2;
  logic [7:0]  out_data0, out_data1, out_data2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [1:0]  out_ch0, out_ch1, out_ch2;
  logic        out_ready0, out_ready1, out_ready2;

  assign in_data0   = {st_dat[0][3], st_dat[0][2], st_dat[0][1], st_dat[0][0]};
  assign in_data1   = {st_dat[1][3], st_dat[1][2], st_dat[1][1], st_dat[1][0]};
  assign in_data2   = {st_dat[2][2], st_dat[2][1], st_dat[2][0]};
  assign in_valid0  = st_v[0];
  assign in_valid1  = st_v[1];
  assign in_valid2  = st_v[2][2:0];
  assign sel0       = st_sel[0];
  assign sel1       = st_sel[1];
  assign sel2       = st_sel[2];
  assign out_ready0 = st_rdy[0];
  assign out_ready1 = st_rdy[1];
  assign out_ready2 = st_rdy[2];

  logic [3:0] obs_rdy   [3];
  logic       obs_valid [3];
  logic [7:0] obs_data  [3];
  logic [1:0] obs_ch    [3];

  assign obs_rdy[0]   = in_ready0;
  assign obs_rdy[1]   = in_ready1;
  assign obs_rdy[2]   = {1'b0, in_ready2};
  assign obs_valid[0] = out_valid0;
  assign obs_valid[1] = out_valid1;
  assign obs_valid[2] = out_valid2;
  assign obs_data[0]  = out_data0;
  assign obs_data[1]  = out_data1;
  assign obs_data[2]  = out_data2;
  assign obs_ch[0]    = out_ch0;
  assign obs_ch[1]    = out_ch1;
  assign obs_ch[2]    = out_ch2;

  muxn_pipe #(.WIDTH(8), .N(4), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .sel(sel0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ch(out_ch0), .out_ready(out_ready0)
  );

  muxn_pipe #(.WIDTH(8), .N(4), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sel(sel1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ch(out_ch1), .out_ready(out_ready1)
  );

  muxn_pipe #(.WIDTH(8), .N(3), .MODE(0)) u_m3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .sel(sel2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ch(out_ch2), .out_ready(out_ready2)
  );

  // ---------------- scoreboard / reference model ----------------
  // Each output register is a one-entry FIFO of {channel, data}.
  logic [9:0] exp_q [3][$];
  int         m_ptr [3];
  int         total = 0;
  int         bad   = 0;

  function automatic int n_of(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic bit rr_of(input int d);
    return (d == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      m_ptr[d] = 0;
    end
  endtask

  // Called at a negedge with stimulus in place: check, clock once, update model.
  task automatic step();
    int         g_a [3];
    bit         x_a [3];
    bit         acc;
    int         c;
    logic [3:0] exp_rdy;
    #1;
    for (int d = 0; d < 3; d++) begin
      acc = (exp_q[d].size() == 0) || st_rdy[d];
      g_a[d] = -1;
      if (!rr_of(d)) begin
        if (int'(st_sel[d]) < n_of(d)) g_a[d] = int'(st_sel[d]);
      end else begin
        for (int k = 0; k < n_of(d); k++) begin
          c = (m_ptr[d] + k) % n_of(d);
          if (g_a[d] < 0 && st_v[d][c]) g_a[d] = c;
        end
      end
      exp_rdy = (g_a[d] >= 0 && acc) ? (4'b0001 << g_a[d]) : 4'b0000;
      x_a[d]  = (g_a[d] >= 0) && acc && st_v[d][g_a[d]];
      check($sformatf("in_ready[%0d]", d), 32'(obs_rdy[d]), 32'(exp_rdy));
      check($sformatf("out_valid[%0d]", d), 32'(obs_valid[d]), 32'(exp_q[d].size() != 0));
      if (exp_q[d].size() != 0) begin
        check($sformatf("out_data[%0d]", d), 32'(obs_data[d]), 32'(exp_q[d][0][7:0]));
        check($sformatf("out_ch[%0d]", d), 32'(obs_ch[d]), 32'(exp_q[d][0][9:8]));
      end
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (exp_q[d].size() != 0 && st_rdy[d]) void'(exp_q[d].pop_front());
      if (x_a[d]) begin
        exp_q[d].push_back({2'(g_a[d]), st_dat[d][g_a[d]]});
        if (rr_of(d)) m_ptr[d] = (g_a[d] + 1) % n_of(d);
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_valid[%0d]", tag, d), 32'(obs_valid[d]), 32'd0);
      check($sformatf("%s_data[%0d]", tag, d), 32'(obs_data[d]), 32'd0);
      check($sformatf("%s_ch[%0d]", tag, d), 32'(obs_ch[d]), 32'd0);
      check($sformatf("%s_rdy[%0d]", tag, d), 32'(obs_rdy[d]), 32'd0);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      st_v[d]   = '0;
      st_sel[d] = '0;
      st_rdy[d] = 1'b1;
      for (int k = 0; k < 4; k++) st_dat[d][k] = 8'(8'h10 * d + k);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_all();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    // T2: MODE0 select channel 2
    st_sel[0] = 2'd2; st_v[0] = 4'b0100; st_dat[0][2] = 8'hA5; st_rdy[0] = 1'b1;
    #1 check("t2_in_ready", 32'(in_ready0), 32'h4);
    step();
    check("t2_data", 32'(out_data0), 32'hA5);
    check("t2_ch", 32'(out_ch0), 32'd2);
    check("t2_valid", 32'(out_valid0), 32'd1);

    // T3: stall for 3 cycles, then pop and push together
    st_rdy[0] = 1'b0; st_dat[0][2] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall_rdy", 32'(in_ready0), 32'h0);
      step();
      check("t3_hold", 32'(out_data0), 32'hA5);
    end
    st_rdy[0] = 1'b1; st_dat[0][2] = 8'h3C;
    step();
    check("t3_new", 32'(out_data0), 32'h3C);
    check("t3_valid", 32'(out_valid0), 32'd1);
    st_v[0] = '0;
    step();
    check("t3_drain", 32'(out_valid0), 32'd0);

    // T4: MODE1 fairness with all channels valid (7 grants leaves ptr=3)
    st_v[1] = 4'b1111; st_rdy[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("t4_ch", 32'(out_ch1), 32'(i % 4));
      check("t4_valid", 32'(out_valid1), 32'd1);
    end

    // T5: skip and wrap from ptr=3
    st_v[1] = 4'b0010;
    #1 check("t5_in_ready", 32'(in_ready1), 32'h2);
    step();
    check("t5_ch1", 32'(out_ch1), 32'd1);
    st_v[1] = 4'b0000;
    step();
    check("t5_empty", 32'(out_valid1), 32'd0);
    st_v[1] = 4'b1001;
    step();
    check("t5_ptr2_pick", 32'(out_ch1), 32'd3);
    st_v[1] = 4'b0000;
    step();

    // T6: N=3, sel=3 is out of range
    st_sel[2] = 2'd3; st_v[2] = 4'b0111; st_rdy[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t6_in_ready", 32'(in_ready2), 32'h0);
      step();
      check("t6_valid", 32'(out_valid2), 32'd0);
    end
    st_v[2] = '0;

    // T1: async reset with a held word and a non-zero rr pointer
    st_sel[0] = 2'd1; st_v[0] = 4'b0010; st_dat[0][1] = 8'h5A;
    st_v[1] = 4'b0001;
    step();
    st_rdy[0] = 1'b0; st_v[0] = '0; st_v[1] = '0;
    check("t1_pre_valid", 32'(out_valid0), 32'd1);
    #2 rst_n = 1'b0;
    reset_checks("t1");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    st_rdy[0] = 1'b1; st_v[1] = 4'b1111;
    step();
    check("t1_ptr0", 32'(out_ch1), 32'd0);
    st_v[1] = '0;
    step();

    // Random phase with one mid-run reset
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        st_v[d]   = 4'($urandom_range(0, 15));
        st_sel[d] = 2'($urandom_range(0, 3));
        st_rdy[d] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) st_dat[d][k] = 8'($urandom_range(0, 255));
      end
      if (cyc == 200) begin
        #2 rst_n = 1'b0;
        reset_checks("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
